// File: rtl/div_share_ctrl.sv
// Shared iterative restoring divider with round-robin request arbitration.
// Serves one request at a time and produces one quotient bit per clock.
module div_share_ctrl #(
    parameter int WIDTH = 56,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quot,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_div0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]   cnt;
    logic            div0_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            found;
    logic            hs;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    logic [WIDTH:0]   shifted;
    logic            ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dq_nx;

    // Round-robin search upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!found && req_valid[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDW'(k);
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign a_sel     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(grant_idx)*WIDTH +: WIDTH];

    // One restoring step; the compare uses one extra bit so it never wraps.
    always_comb begin
        shifted = {rem_q, dq_q[WIDTH-1]};
        ge      = shifted >= {1'b0, b_q};
        rem_nx  = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
        dq_nx   = {dq_q[WIDTH-2:0], ge};
    end

    // Control FSM with operand datapath and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            dq_q      <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt       <= '0;
            div0_q    <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_quot  <= '0;
            rsp_rem   <= '0;
            rsp_div0  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        dq_q   <= a_sel;
                        b_q    <= b_sel;
                        div0_q <= (b_sel == '0);
                        id_q   <= grant_idx;
                        rem_q  <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        state  <= ITER;
                        if (int'(grant_idx) == NREQ - 1) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_idx + 1'b1;
                        end
                    end
                end
                ITER: begin
                    rem_q <= rem_nx;
                    dq_q  <= dq_nx;
                    if (cnt == '0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_quot  <= dq_nx;
                        rsp_rem   <= rem_nx;
                        rsp_div0  <= div0_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_div0  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: directed cases then random traffic.
// Expected results come from constants or a/b, a%b on bench-owned operands.
module tb_div_share_ctrl;

    localparam int WIDTH = 56;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = WIDTH + 1;
    localparam int NRAND = 800;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        word_t a;
        word_t b;
        word_t q;
        word_t r;
        logic  z;
    } job_t;

    typedef struct {
        int    id;
        word_t q;
        word_t r;
        logic  z;
        int    cyc;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  busy;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    word_t                 rsp_quot;
    word_t                 rsp_rem;
    logic                  rsp_div0;

    div_share_ctrl #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .busy     (busy),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_quot (rsp_quot),
        .rsp_rem  (rsp_rem),
        .rsp_div0 (rsp_div0)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_rsp    = 0;
    int n_exp    = 0;

    job_t jobs[NREQ][$];
    exp_t sb[$];
    int   hs_ids[$];
    int   hs_cycs[$];

    logic [NREQ-1:0] hs_vec = '0;
    logic [NREQ-1:0] mon_eg;
    logic [NREQ-1:0] mon_hs;
    int              busy_cnt = 0;
    int              tb_rr    = 0;
    logic            rnd_mode = 1'b0;
    word_t           last_q   = '0;
    word_t           last_r   = '0;
    logic [IDW-1:0]  last_id  = '0;
    exp_t            mon_e;
    job_t            mon_j;
    int              mon_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant(
        input logic [NREQ-1:0] v, input int rr);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (rr + i) % NREQ;
            if (v[k]) return NREQ'(1) << k;
        end
        return '0;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w = word_t'({$urandom, $urandom});
        w = w >> $urandom_range(WIDTH - 1, 0);
        return w;
    endfunction

    task automatic add_job(input int id, input word_t a, input word_t b,
                           input word_t q, input word_t r, input logic z);
        job_t j;
        j.a = a;
        j.b = b;
        j.q = q;
        j.r = r;
        j.z = z;
        jobs[id].push_back(j);
        n_exp++;
    endtask

    function automatic int pending();
        int n;
        n = sb.size() + busy_cnt;
        for (int i = 0; i < NREQ; i++) n += jobs[i].size();
        return n;
    endfunction

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (pending() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (n >= lim) chk("drain_timeout", 1, 0);
    endtask

    // Monitor: grant/busy model, scoreboard push on accept, pop on response.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            busy_cnt = 0;
            tb_rr    = 0;
            hs_vec   = '0;
            last_q   = '0;
            last_r   = '0;
            last_id  = '0;
        end else begin
            chk("busy", busy, busy_cnt > 0);
            mon_eg = (busy_cnt > 0) ? '0 : model_grant(req_valid, tb_rr);
            chk("req_ready", req_ready, mon_eg);
            mon_hs = req_valid & req_ready;
            hs_vec = mon_hs;
            if (rsp_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_quot", rsp_quot, mon_e.q);
                    chk("rsp_rem", rsp_rem, mon_e.r);
                    chk("rsp_div0", rsp_div0, mon_e.z);
                    chk("latency", cyc - mon_e.cyc, LAT);
                end
                last_q  = rsp_quot;
                last_r  = rsp_rem;
                last_id = rsp_id;
            end else begin
                chk("hold_quot", rsp_quot, last_q);
                chk("hold_rem", rsp_rem, last_r);
                chk("hold_id", rsp_id, last_id);
            end
            if (busy_cnt > 0) busy_cnt--;
            if (mon_hs != '0) begin
                mon_g = 0;
                for (int i = 0; i < NREQ; i++) if (mon_hs[i]) mon_g = i;
                if (jobs[mon_g].size() > 0) begin
                    mon_j     = jobs[mon_g][0];
                    mon_e.id  = mon_g;
                    mon_e.q   = mon_j.q;
                    mon_e.r   = mon_j.r;
                    mon_e.z   = mon_j.z;
                    mon_e.cyc = cyc;
                    sb.push_back(mon_e);
                end
                busy_cnt = LAT;
                tb_rr    = (mon_g + 1) % NREQ;
                hs_ids.push_back(mon_g);
                hs_cycs.push_back(cyc);
            end
        end
    end

    // Requester driver: holds each job until accepted, random gaps if enabled.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req_valid = '0;
                continue;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (hs_vec[i]) begin
                    if (jobs[i].size() > 0) void'(jobs[i].pop_front());
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && jobs[i].size() > 0 &&
                    (!rnd_mode || $urandom_range(1, 0) == 1)) begin
                    req_a[i*WIDTH +: WIDTH] = jobs[i][0].a;
                    req_b[i*WIDTH +: WIDTH] = jobs[i][0].b;
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && rnd_mode && !busy &&
                             $urandom_range(3, 0) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t mx;
        word_t a;
        word_t b;
        int    n;
        int    id;
        mx  = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_quot", rsp_quot, 0);
        chk("rst_rsp_rem", rsp_rem, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        hs_ids.delete();
        hs_cycs.delete();
        for (int i = 0; i < NREQ; i++) add_job(i, 1000 + i, 10, 100, i, 0);
        add_job(0, 1000, 10, 100, 0, 0);
        drain(1000);
        chk("rr_count", hs_ids.size(), 5);
        if (hs_ids.size() == 5) begin
            chk("rr_order0", hs_ids[0], 0);
            chk("rr_order1", hs_ids[1], 1);
            chk("rr_order2", hs_ids[2], 2);
            chk("rr_order3", hs_ids[3], 3);
            chk("rr_order4", hs_ids[4], 0);
            for (int i = 1; i < 5; i++)
                chk("rr_spacing", hs_cycs[i] - hs_cycs[i-1], WIDTH + 2);
        end

        add_job(0, 100, 7, 14, 2, 0);
        drain(200);

        add_job(1, mx, 1, mx, 0, 0);
        add_job(3, 5, 9, 0, 5, 0);
        add_job(0, mx, mx, 1, 0, 0);
        add_job(2, 0, 13, 0, 0, 0);
        drain(600);

        add_job(2, 'h123, 0, mx, 'h123, 1);
        drain(200);

        n = hs_ids.size();
        add_job(1, 50, 5, 10, 0, 0);
        n_exp--;
        id = 0;
        while (hs_ids.size() == n && id < 50) begin
            @(posedge clk);
            id++;
        end
        if (id >= 50) chk("rst_mid_accept_timeout", 1, 0);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) jobs[i].delete();
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_quot", rsp_quot, 0);
        chk("mid_rst_rsp_rem", rsp_rem, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        add_job(3, 50, 5, 10, 0, 0);
        drain(200);
        chk("post_rst_first_id", hs_ids[hs_ids.size()-1], 3);

        rnd_mode = 1'b1;
        for (int k = 0; k < NRAND; k++) begin
            id = $urandom_range(NREQ - 1, 0);
            a  = rand_word();
            case ($urandom_range(9, 0))
                0: b = '0;
                1: b = 1;
                default: b = rand_word();
            endcase
            if (b == '0) add_job(id, a, b, mx, a, 1);
            else add_job(id, a, b, a / b, a % b, 0);
        end
        drain(NRAND * 90);
        repeat (3) @(posedge clk);
        #2;
        chk("rsp_count", n_rsp, n_exp);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
